pipe_flopr: RTL and testbench

//  Parametrised elastic register pipeline: DEPTH stages of WIDTH-bit data with per-stage valid.

---
 rtl/pipe_flopr_stage.sv | 61 ++++++
 rtl/pipe_flopr.sv | 84 ++++++++
 tb/tb_pipe_flopr.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/pipe_flopr_stage.sv
// ============================================================================
// Module  : pipe_flopr_stage
// Purpose : One elastic pipeline slot: a valid bit plus a data register.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_flopr_stage #(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] RESET_VAL  = '0,
  parameter bit               FLUSH_DATA = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             down_ready_i,
  output logic             valid_o,
  output logic             ready_o,
  output logic             move_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    move_o  = valid_q & down_ready_i;
    ready_o = ~valid_q | move_o;

    valid_d = valid_q;
    data_d  = data_q;
    if (flush_i) begin
      valid_d = 1'b0;
      if (FLUSH_DATA) data_d = RESET_VAL;
    end else if (load_i) begin
      // A load may coincide with the current word leaving; the new word wins.
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (move_o) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= RESET_VAL;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

`default_nettype wire

// File: rtl/pipe_flopr.sv
// ============================================================================
// Module  : pipe_flopr
// Purpose : Elastic DEPTH-stage register pipeline with valid/ready, flush, count.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_flopr #(
  parameter int               WIDTH      = 8,
  parameter int               DEPTH      = 3,
  parameter logic [WIDTH-1:0] RESET_VAL  = '0,
  parameter bit               FLUSH_DATA = 1'b0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CNT_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0] stage_valid;
  logic [DEPTH-1:0] stage_ready;
  logic [DEPTH-1:0] stage_move;
  logic [DEPTH-1:0] stage_load;
  logic [DEPTH-1:0] stage_down_ready;
  logic [WIDTH-1:0] stage_data [DEPTH];
  logic [WIDTH-1:0] stage_src  [DEPTH];

  // Reset gates in_ready so nothing is accepted while the pipe is held clear.
  assign in_ready = stage_ready[0] & ~flush & ~reset;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign stage_load[k] = in_valid & in_ready;
      assign stage_src[k]  = in_data;
    end else begin : g_body
      assign stage_load[k] = stage_move[k-1];
      assign stage_src[k]  = stage_data[k-1];
    end

    if (k == DEPTH-1) begin : g_tail
      assign stage_down_ready[k] = out_ready;
    end else begin : g_mid
      assign stage_down_ready[k] = stage_ready[k+1];
    end

    pipe_flopr_stage #(
      .WIDTH      (WIDTH),
      .RESET_VAL  (RESET_VAL),
      .FLUSH_DATA (FLUSH_DATA)
    ) u_stage (
      .clk          (clk),
      .reset        (reset),
      .flush_i      (flush),
      .load_i       (stage_load[k]),
      .data_i       (stage_src[k]),
      .down_ready_i (stage_down_ready[k]),
      .valid_o      (stage_valid[k]),
      .ready_o      (stage_ready[k]),
      .move_o       (stage_move[k]),
      .data_o       (stage_data[k])
    );
  end

  assign out_valid = stage_valid[DEPTH-1];
  assign out_data  = stage_data[DEPTH-1];

  always_comb begin
    count = '0;
    for (int k = 0; k < DEPTH; k++) begin
      count = count + CNT_W'(stage_valid[k]);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pipe_flopr.sv
// ============================================================================
// Module  : tb_pipe_flopr
// Purpose : Directed vector bench for pipe_flopr (WIDTH=8, DEPTH=3, RESET_VAL=A5).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pipe_flopr;

  localparam int WIDTH = 8;
  localparam int DEPTH = 3;

  logic             clk;
  logic             reset;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       count;

  int total;
  int bad;

  pipe_flopr #(
    .WIDTH      (WIDTH),
    .DEPTH      (DEPTH),
    .RESET_VAL  (8'hA5),
    .FLUSH_DATA (1'b1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       iv;
    logic [7:0] din;
    logic       ordy;
    logic       fl;
    logic       e_ir;
    logic       e_ov;
    logic [7:0] e_od;
    logic [1:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic iv, input logic [7:0] din, input logic ordy,
                     input logic fl, input logic e_ir, input logic e_ov,
                     input logic [7:0] e_od, input logic [1:0] e_cnt);
    vec_t v;
    v.iv = iv; v.din = din; v.ordy = ordy; v.fl = fl;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.e_cnt = e_cnt;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive after the falling edge, settle, then check pre-edge outputs.
  task automatic drive(input logic iv, input logic [7:0] din, input logic ordy, input logic fl);
    @(negedge clk);
    in_valid  = iv;
    in_data   = din;
    out_ready = ordy;
    flush     = fl;
    #1;
  endtask

  task automatic chk_state(input string name, input logic e_ir, input logic e_ov,
                           input logic [7:0] e_od, input logic [1:0] e_cnt);
    chk({name, ".in_ready"},  in_ready,  e_ir);
    chk({name, ".out_valid"}, out_valid, e_ov);
    if (e_ov) chk({name, ".out_data"}, out_data, e_od);
    chk({name, ".count"},     count,     e_cnt);
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;

    // Stream 10..12, then out_ready=0 fill with 20..24, then single word 30.
    add(1, 8'h10, 1, 0, 1, 0, 8'h00, 0);
    add(1, 8'h11, 1, 0, 1, 0, 8'h00, 1);
    add(1, 8'h12, 1, 0, 1, 0, 8'h00, 2);
    add(0, 8'h00, 1, 0, 1, 1, 8'h10, 3);
    add(0, 8'h00, 1, 0, 1, 1, 8'h11, 2);
    add(0, 8'h00, 1, 0, 1, 1, 8'h12, 1);
    add(1, 8'h20, 0, 0, 1, 0, 8'h00, 0);
    add(1, 8'h21, 0, 0, 1, 0, 8'h00, 1);
    add(1, 8'h22, 0, 0, 1, 0, 8'h00, 2);
    add(1, 8'h23, 0, 0, 0, 1, 8'h20, 3);
    add(1, 8'h23, 1, 0, 1, 1, 8'h20, 3);
    add(1, 8'h24, 1, 0, 1, 1, 8'h21, 3);
    add(0, 8'h00, 1, 0, 1, 1, 8'h22, 3);
    add(0, 8'h00, 1, 0, 1, 1, 8'h23, 2);
    add(0, 8'h00, 1, 0, 1, 1, 8'h24, 1);
    add(0, 8'h00, 1, 0, 1, 0, 8'h00, 0);
    add(1, 8'h30, 0, 0, 1, 0, 8'h00, 0);
    add(0, 8'hFF, 0, 0, 1, 0, 8'h00, 1);
    add(0, 8'hEE, 0, 0, 1, 0, 8'h00, 1);
    add(0, 8'h00, 0, 0, 1, 1, 8'h30, 1);
    add(0, 8'h00, 1, 0, 1, 1, 8'h30, 1);
    add(0, 8'h00, 0, 0, 1, 0, 8'h00, 0);

    // Reset state while reset is held.
    #2;
    chk("rst.in_ready",  in_ready,  1'b0);
    chk("rst.out_valid", out_valid, 1'b0);
    chk("rst.out_data",  out_data,  8'hA5);
    chk("rst.count",     count,     2'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].iv, vecs[i].din, vecs[i].ordy, vecs[i].fl);
      chk_state($sformatf("vec%0d", i), vecs[i].e_ir, vecs[i].e_ov, vecs[i].e_od, vecs[i].e_cnt);
    end

    // Full pipe streaming: keeps accepting while delivering in order.
    drive(1, 8'h40, 0, 0);
    drive(1, 8'h41, 0, 0);
    drive(1, 8'h42, 0, 0);
    for (int i = 0; i < 4; i++) begin
      drive(1, 8'(8'h43 + i), 1, 0);
      chk_state($sformatf("full%0d", i), 1'b1, 1'b1, 8'(8'h40 + i), 2'd3);
    end

    // Pipe now holds 44,45,46: flush with input offered.
    drive(1, 8'h77, 0, 1);
    chk_state("flush.pre", 1'b0, 1'b1, 8'h44, 2'd3);
    drive(0, 8'h00, 0, 0);
    chk_state("flush.post", 1'b1, 1'b0, 8'h00, 2'd0);
    chk("flush.out_data", out_data, 8'hA5);

    // Refill, then assert reset between edges.
    drive(1, 8'h50, 0, 0);
    drive(1, 8'h51, 0, 0);
    drive(1, 8'h52, 0, 0);
    drive(0, 8'h00, 0, 0);
    chk_state("refill", 1'b0, 1'b1, 8'h50, 2'd3);
    #1;
    reset = 1'b1;
    #1;
    chk("async.out_valid", out_valid, 1'b0);
    chk("async.out_data",  out_data,  8'hA5);
    chk("async.count",     count,     2'd0);
    chk("async.in_ready",  in_ready,  1'b0);
    @(negedge clk);
    reset = 1'b0;
    drive(0, 8'h00, 1, 0);
    chk_state("post_rst", 1'b1, 1'b0, 8'h00, 2'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
